ysyx_25010008_wbu: RTL and testbench

Write-back/commit unit of the ysyx_25010008 core: the writer side of the register file. It accepts one retired instruction per handshake from the execute stage, waits for load data when needed, and formats it. In a single commit cycle it drives the GPR write port and the two CSR write ports. It also raises a PC redirect for ecall/mret and a commit strobe for the difftest harness.

---
 rtl/ysyx_25010008_wbu_if.sv | 29 ++
 rtl/ysyx_25010008_wbu.sv | 175 +++++++++++++++++
 tb/tb_ysyx_25010008_wbu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25010008_wbu_if.sv
// Execute-to-writeback handshake: one retired instruction per in_valid/in_ready transfer.
interface ysyx_25010008_wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic [1:0]  in_addr_lo;
  logic [1:0]  in_sys_op;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_old;
  logic [31:0] in_csr_new;

  modport master (
    output in_valid, in_pc, in_rd, in_wen, in_result, in_is_load, in_load_size,
           in_load_signed, in_addr_lo, in_sys_op, in_csr_addr, in_csr_old, in_csr_new,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_rd, in_wen, in_result, in_is_load, in_load_size,
           in_load_signed, in_addr_lo, in_sys_op, in_csr_addr, in_csr_old, in_csr_new,
    output in_ready
  );
endinterface

// File: rtl/ysyx_25010008_wbu.sv
// Write-back/commit unit: latches a retired instruction, waits for load data if needed, and
// drives GPR/CSR write ports, PC redirect and difftest commit for exactly one cycle.
module ysyx_25010008_wbu #(
  parameter logic [31:0] CAUSE_ECALL = 32'd11
) (
  input  logic                       clock,
  input  logic                       reset,
  ysyx_25010008_wbu_if.slave         in_if,
  input  logic                       mem_rvalid,
  input  logic [31:0]                mem_rdata,
  output logic                       mem_rready,
  output logic                       write_back,
  output logic                       wen,
  output logic [4:0]                 rd,
  output logic [31:0]                wdata,
  output logic                       csr_wen1,
  output logic [11:0]                csr_d1,
  output logic [31:0]                csr_wdata1,
  output logic                       csr_wen2,
  output logic [11:0]                csr_d2,
  output logic [31:0]                csr_wdata2,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic                       commit_valid,
  output logic [31:0]                commit_pc
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] result;
    logic        is_load;
    logic [1:0]  load_size;
    logic        load_signed;
    logic [1:0]  addr_lo;
    logic [1:0]  sys_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
  } fields_t;

  typedef struct packed {
    logic        write_back;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        csr_wen1;
    logic [11:0] csr_d1;
    logic [31:0] csr_wdata1;
    logic        csr_wen2;
    logic [11:0] csr_d2;
    logic [31:0] csr_wdata2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] commit_pc;
  } commit_t;

  state_e  state_q;
  fields_t fields_q, in_fields, src;
  commit_t commit_d, commit_q;
  logic    accept, commit_go;
  logic [31:0] shifted, load_val;

  assign in_fields = '{
    pc:          in_if.in_pc,
    rd:          in_if.in_rd,
    wen:         in_if.in_wen,
    result:      in_if.in_result,
    is_load:     in_if.in_is_load,
    load_size:   in_if.in_load_size,
    load_signed: in_if.in_load_signed,
    addr_lo:     in_if.in_addr_lo,
    sys_op:      in_if.in_sys_op,
    csr_addr:    in_if.in_csr_addr,
    csr_old:     in_if.in_csr_old,
    csr_new:     in_if.in_csr_new
  };

  assign in_if.in_ready = (state_q == StIdle) && !reset;
  assign mem_rready     = (state_q == StWaitMem) && !reset;

  assign accept    = (state_q == StIdle) && in_if.in_valid;
  assign commit_go = (accept && !in_if.in_is_load) || ((state_q == StWaitMem) && mem_rvalid);
  // Non-loads commit straight from the inputs; loads commit from the latched copy.
  assign src       = (state_q == StIdle) ? in_fields : fields_q;

  always_comb begin
    shifted = mem_rdata >> {fields_q.addr_lo, 3'b000};
    unique case (fields_q.load_size)
      2'd0:    load_val = {{24{fields_q.load_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{fields_q.load_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    commit_d = '0;
    if (commit_go) begin
      commit_d.write_back = 1'b1;
      commit_d.commit_pc  = src.pc;
      commit_d.rd         = src.rd;
      commit_d.wen        = src.wen && (src.rd != 5'd0);
      if (src.is_load) begin
        commit_d.wdata = load_val;
      end else if (src.sys_op == 2'd1) begin
        commit_d.wdata = src.csr_old;
      end else begin
        commit_d.wdata = src.result;
      end
      unique case (src.sys_op)
        2'd1: begin
          commit_d.csr_wen1   = 1'b1;
          commit_d.csr_d1     = src.csr_addr;
          commit_d.csr_wdata1 = src.csr_new;
        end
        2'd2: begin
          commit_d.wen            = 1'b0;
          commit_d.csr_wen1       = 1'b1;
          commit_d.csr_d1         = 12'h341;
          commit_d.csr_wdata1     = src.pc;
          commit_d.csr_wen2       = 1'b1;
          commit_d.csr_d2         = 12'h342;
          commit_d.csr_wdata2     = CAUSE_ECALL;
          commit_d.redirect_valid = 1'b1;
          commit_d.redirect_pc    = src.csr_old;
        end
        2'd3: begin
          commit_d.wen            = 1'b0;
          commit_d.redirect_valid = 1'b1;
          commit_d.redirect_pc    = src.csr_old;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      fields_q <= '0;
      commit_q <= '0;
    end else begin
      commit_q <= commit_d;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            fields_q <= in_fields;
            state_q  <= in_if.in_is_load ? StWaitMem : StCommit;
          end
        end
        StWaitMem: if (mem_rvalid) state_q <= StCommit;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign write_back     = commit_q.write_back;
  assign commit_valid   = commit_q.write_back;
  assign wen            = commit_q.wen;
  assign rd             = commit_q.rd;
  assign wdata          = commit_q.wdata;
  assign csr_wen1       = commit_q.csr_wen1;
  assign csr_d1         = commit_q.csr_d1;
  assign csr_wdata1     = commit_q.csr_wdata1;
  assign csr_wen2       = commit_q.csr_wen2;
  assign csr_d2         = commit_q.csr_d2;
  assign csr_wdata2     = commit_q.csr_wdata2;
  assign redirect_valid = commit_q.redirect_valid;
  assign redirect_pc    = commit_q.redirect_pc;
  assign commit_pc      = commit_q.commit_pc;

endmodule

// File: tb/tb_ysyx_25010008_wbu.sv
// Directed plus randomized bench for the write-back unit against an arithmetic reference model.
module tb_ysyx_25010008_wbu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic mem_rready, write_back, wen, csr_wen1, csr_wen2, redirect_valid, commit_valid;
  logic [4:0] rd;
  logic [11:0] csr_d1, csr_d2;
  logic [31:0] wdata, csr_wdata1, csr_wdata2, redirect_pc, commit_pc;
  int tests = 0;
  int fails = 0;

  ysyx_25010008_wbu_if ifc ();

  ysyx_25010008_wbu dut (
    .clock(clock), .reset(reset), .in_if(ifc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .write_back(write_back), .wen(wen), .rd(rd), .wdata(wdata),
    .csr_wen1(csr_wen1), .csr_d1(csr_d1), .csr_wdata1(csr_wdata1),
    .csr_wen2(csr_wen2), .csr_d2(csr_d2), .csr_wdata2(csr_wdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] result;
    logic        is_load;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  alo;
    logic [1:0]  sys;
    logic [11:0] caddr;
    logic [31:0] cold;
    logic [31:0] cnew;
  } txn_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input txn_t t);
    ifc.in_pc = t.pc; ifc.in_rd = t.rd; ifc.in_wen = t.wen; ifc.in_result = t.result;
    ifc.in_is_load = t.is_load; ifc.in_load_size = t.size; ifc.in_load_signed = t.sgn;
    ifc.in_addr_lo = t.alo; ifc.in_sys_op = t.sys; ifc.in_csr_addr = t.caddr;
    ifc.in_csr_old = t.cold; ifc.in_csr_new = t.cnew;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.pc = $urandom; t.rd = 5'($urandom); t.wen = 1'($urandom); t.result = $urandom;
    t.sys = 2'($urandom); t.is_load = (t.sys == 2'd0) && ($urandom_range(0, 1) == 1);
    t.size = 2'($urandom); t.sgn = 1'($urandom); t.alo = 2'($urandom);
    t.caddr = 12'($urandom); t.cold = $urandom; t.cnew = $urandom;
    return t;
  endfunction

  // Reference: pick the addressed byte lane(s) arithmetically, then extend.
  function automatic logic [31:0] load_model(input txn_t t, input logic [31:0] word);
    logic [31:0] v;
    v = word / (32'd1 << (t.alo * 8));
    if (t.size == 2'd0) begin
      v = v % 32'd256;
      if (t.sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (t.size == 2'd1) begin
      v = v % 32'd65536;
      if (t.sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic check_commit(input txn_t t, input logic [31:0] word);
    logic        e_wen, e_c1, e_c2, e_red;
    logic [31:0] e_wdata;
    e_wen   = t.wen && (t.rd != 0) && (t.sys != 2) && (t.sys != 3);
    e_c1    = (t.sys == 1) || (t.sys == 2);
    e_c2    = (t.sys == 2);
    e_red   = (t.sys == 2) || (t.sys == 3);
    e_wdata = t.is_load ? load_model(t, word) : ((t.sys == 1) ? t.cold : t.result);
    chk("write_back", 32'(write_back), 32'd1);
    chk("commit_valid", 32'(commit_valid), 32'd1);
    chk("commit_pc", commit_pc, t.pc);
    chk("wen", 32'(wen), 32'(e_wen));
    chk("wdata", wdata, e_wdata);
    if (e_wen) chk("rd", 32'(rd), 32'(t.rd));
    chk("csr_wen1", 32'(csr_wen1), 32'(e_c1));
    chk("csr_wen2", 32'(csr_wen2), 32'(e_c2));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_red));
    if (t.sys == 1) begin
      chk("csr_d1", 32'(csr_d1), 32'(t.caddr));
      chk("csr_wdata1", csr_wdata1, t.cnew);
    end
    if (t.sys == 2) begin
      chk("csr_d1", 32'(csr_d1), 32'h341);
      chk("csr_wdata1", csr_wdata1, t.pc);
      chk("csr_d2", 32'(csr_d2), 32'h342);
      chk("csr_wdata2", csr_wdata2, 32'd11);
    end
    if (e_red) chk("redirect_pc", redirect_pc, t.cold);
  endtask

  task automatic run_txn(input txn_t t, input logic [31:0] word, input int waits);
    drive(t);
    ifc.in_valid = 1'b1;
    chk("in_ready_idle", 32'(ifc.in_ready), 32'd1);
    tick();
    // Scramble the inputs right after accept to prove the fields were latched.
    drive(rand_txn());
    if (t.is_load) begin
      for (int i = 0; i < waits; i++) begin
        chk("mem_rready_wait", 32'(mem_rready), 32'd1);
        chk("in_ready_wait", 32'(ifc.in_ready), 32'd0);
        chk("wb_wait", 32'(write_back), 32'd0);
        mem_rdata = $urandom;
        tick();
      end
      mem_rdata  = word;
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    check_commit(t, word);
    chk("in_ready_commit", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    tick();
    chk("wb_after", 32'(write_back), 32'd0);
    chk("in_ready_after", 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    txn_t t;
    ifc.in_valid = 1'b0;
    drive(rand_txn());
    tick();
    tick();
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_mem_rready", 32'(mem_rready), 32'd0);
    chk("rst_wb", 32'(write_back), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("post_rst_mem_rready", 32'(mem_rready), 32'd0);

    // ALU op
    t = rand_txn();
    t.rd = 5'd5; t.wen = 1'b1; t.result = 32'h1234; t.is_load = 1'b0; t.sys = 2'd0;
    run_txn(t, 32'h0, 0);

    // Signed then unsigned byte load at lane 3, three wait cycles
    t = rand_txn();
    t.sys = 2'd0; t.is_load = 1'b1; t.size = 2'd0; t.sgn = 1'b1; t.alo = 2'd3;
    t.rd = 5'd7; t.wen = 1'b1;
    run_txn(t, 32'h80FF_0000, 3);
    chk("dir_sbyte", load_model(t, 32'h80FF_0000), 32'hFFFF_FF80);
    t.sgn = 1'b0;
    run_txn(t, 32'h80FF_0000, 3);

    // ecall
    t = rand_txn();
    t.sys = 2'd2; t.is_load = 1'b0; t.pc = 32'h8000_0010; t.cold = 32'h8000_0100;
    t.wen = 1'b1; t.rd = 5'd1;
    run_txn(t, 32'h0, 0);

    // csrrw to x0
    t = rand_txn();
    t.sys = 2'd1; t.is_load = 1'b0; t.rd = 5'd0; t.wen = 1'b1;
    t.caddr = 12'h305; t.cnew = 32'h8000_0200;
    run_txn(t, 32'h0, 0);

    // Reset while waiting for memory drops the load
    t = rand_txn();
    t.sys = 2'd0; t.is_load = 1'b1; t.rd = 5'd9; t.wen = 1'b1;
    drive(t);
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    chk("rst_wm_mem_rready", 32'(mem_rready), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_wm_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_wm_wb", 32'(write_back), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_wm_ready_after", 32'(ifc.in_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wm_no_wb", 32'(write_back), 32'd0);
      chk("rst_wm_no_rready", 32'(mem_rready), 32'd0);
      tick();
    end

    for (int n = 0; n < 60; n++) begin
      run_txn(rand_txn(), $urandom, $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
